// File: rtl/matrix_seq_if.sv
// Control and address bus of the matrix sweep sequencer.
// The slave side is the sequencer; the master side drives trigger, mode and limits.
interface matrix_seq_if #(
    parameter int ROW_W     = 5,
    parameter int COL_W     = 13,
    parameter int IN_ADR_W  = 6,
    parameter int COE_ADR_W = 10
);
    logic                 trg;
    logic                 abort;
    logic                 stall;
    logic                 mode;
    logic [ROW_W-1:0]     row_last;
    logic [COL_W-1:0]     col_last;
    logic [IN_ADR_W-1:0]  in_adr;
    logic [COE_ADR_W-1:0] coe_adr;
    logic [ROW_W-1:0]     row_cnt;
    logic [COL_W:0]       col_cnt;
    logic [5:0]           cyc_cnt;
    logic                 vld;
    logic                 tile_last;
    logic                 done;
    logic                 busy;
    logic [1:0]           state;

    modport master (
        output trg, abort, stall, mode, row_last, col_last,
        input  in_adr, coe_adr, row_cnt, col_cnt, cyc_cnt,
        input  vld, tile_last, done, busy, state
    );

    modport slave (
        input  trg, abort, stall, mode, row_last, col_last,
        output in_adr, coe_adr, row_cnt, col_cnt, cyc_cnt,
        output vld, tile_last, done, busy, state
    );
endinterface

// File: rtl/matrix_seq.sv
// Row/column sweep sequencer: walks rows, column blocks of COL_STEP and CYC beats per block,
// producing input and coefficient memory addresses, with single-shot or continuous sweeps.
module matrix_seq #(
    parameter int CYC       = 8,
    parameter int COL_STEP  = 32,
    parameter int ROW_W     = 5,
    parameter int COL_W     = 13,
    parameter int IN_ADR_W  = 6,
    parameter int COE_ADR_W = 10,
    parameter int IN_DIV    = 2
) (
    input  logic         clk,
    input  logic         rst,
    matrix_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        BAD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [IN_ADR_W-1:0]  in_adr;
        logic [COE_ADR_W-1:0] coe_adr;
        logic [ROW_W-1:0]     row;
        logic [COL_W:0]       col;
        logic [5:0]           cyc;
    } ctr_t;

    localparam logic [5:0]     CYC_LAST = 6'(CYC - 1);
    localparam logic [COL_W+1:0] STEP   = (COL_W + 2)'(COL_STEP);

    state_t           state_q;
    ctr_t             ctr_q;
    ctr_t             ctr_adv;
    logic [ROW_W-1:0] row_last_q;
    logic [COL_W-1:0] col_last_q;
    logic             done_q;

    logic beat;
    logic wrap;
    logic lastblk;
    logic row_end;
    logic sweep_end;

    assign beat      = (state_q == RUN) && !bus.stall;
    assign wrap      = (ctr_q.cyc == CYC_LAST);
    // Widened by two bits so the block-end compare cannot wrap near the top of the column range.
    assign lastblk   = ({1'b0, ctr_q.col} + STEP) > {2'b00, col_last_q};
    assign row_end   = wrap && lastblk;
    assign sweep_end = row_end && (ctr_q.row == row_last_q);

    // NOTE: every field gets a default first so this block can never infer a latch.
    always_comb begin
        ctr_adv     = ctr_q;
        ctr_adv.cyc = wrap ? '0 : ctr_q.cyc + 6'(1);

        if (ctr_q.col == '0 && ctr_q.row[IN_DIV-1:0] == '0)
            ctr_adv.in_adr = ctr_q.in_adr + IN_ADR_W'(1);

        if (wrap && lastblk) begin
            ctr_adv.col     = '0;
            ctr_adv.coe_adr = '0;
        end else if (wrap) begin
            ctr_adv.col     = ctr_q.col + STEP[COL_W:0];
            ctr_adv.coe_adr = ctr_q.coe_adr + COE_ADR_W'(1);
        end else begin
            ctr_adv.coe_adr = ctr_q.coe_adr + COE_ADR_W'(1);
        end

        if (row_end)
            ctr_adv.row = ctr_q.row + ROW_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            row_last_q <= '0;
            col_last_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                ctr_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.trg) begin
                            state_q    <= RUN;
                            row_last_q <= bus.row_last;
                            col_last_q <= bus.col_last;
                            ctr_q      <= '0;
                        end
                    end
                    RUN: begin
                        if (beat && sweep_end) begin
                            ctr_q  <= '0;
                            done_q <= 1'b1;
                            if (bus.mode) begin
                                row_last_q <= bus.row_last;
                                col_last_q <= bus.col_last;
                            end else begin
                                state_q <= DONE;
                            end
                        end else if (beat) begin
                            ctr_q <= ctr_adv;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: begin
                        state_q <= IDLE;
                        ctr_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.in_adr    = ctr_q.in_adr;
    assign bus.coe_adr   = ctr_q.coe_adr;
    assign bus.row_cnt   = ctr_q.row;
    assign bus.col_cnt   = ctr_q.col;
    assign bus.cyc_cnt   = ctr_q.cyc;
    assign bus.vld       = beat;
    assign bus.tile_last = beat && wrap && lastblk;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_matrix_seq.sv
// Directed bench for matrix_seq: table-driven sweeps plus hand-written sequences
// for row advance, abort, continuous mode and asynchronous reset.
module tb_matrix_seq;

    logic clk;
    logic rst;

    matrix_seq_if bus_if ();

    matrix_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic stall;
        logic vld;
        int   coe;
        int   in_a;
        int   row;
        int   col;
        int   cyc;
        logic tile;
        logic done;
        logic busy;
        int   st;
    } vec_t;

    vec_t tbl [23];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic s, v, input int coe, ina, row, col, cyc,
                                input logic tl, dn, bz, input int st);
        vec_t e;
        e.stall = s;  e.vld = v;    e.coe  = coe; e.in_a = ina; e.row = row;
        e.col   = col; e.cyc = cyc; e.tile = tl;  e.done = dn;  e.busy = bz; e.st = st;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t e);
        check({tag, ".vld"},       32'(bus_if.vld),       32'(e.vld));
        check({tag, ".coe_adr"},   32'(bus_if.coe_adr),   e.coe);
        check({tag, ".in_adr"},    32'(bus_if.in_adr),    e.in_a);
        check({tag, ".row_cnt"},   32'(bus_if.row_cnt),   e.row);
        check({tag, ".col_cnt"},   32'(bus_if.col_cnt),   e.col);
        check({tag, ".cyc_cnt"},   32'(bus_if.cyc_cnt),   e.cyc);
        check({tag, ".tile_last"}, 32'(bus_if.tile_last), 32'(e.tile));
        check({tag, ".done"},      32'(bus_if.done),      32'(e.done));
        check({tag, ".busy"},      32'(bus_if.busy),      32'(e.busy));
        check({tag, ".state"},     32'(bus_if.state),     e.st);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic m, input int rl, input int cl);
        bus_if.mode     = m;
        bus_if.row_last = 5'(rl);
        bus_if.col_last = 13'(cl);
        bus_if.trg      = 1'b1;
        tick();
        bus_if.trg      = 1'b0;
    endtask

    task automatic run_table(input int lo, input int n);
        for (int i = lo; i < lo + n; i++) begin
            bus_if.stall = tbl[i].stall;
            #1;
            chk_outs($sformatf("tbl%0d", i), tbl[i]);
            tick();
        end
        bus_if.stall = 1'b0;
    endtask

    initial begin
        vec_t zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single sweep, one row, one column block.
        for (int k = 0; k < 8; k++) tbl[k] = mk(0, 1, k, k, 0, 0, k, k == 7, 0, 1, 1);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        tbl[9] = zero;
        // Same sweep with a three-cycle stall at beat 4.
        for (int k = 0; k < 4; k++) tbl[10 + k] = mk(0, 1, k, k, 0, 0, k, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) tbl[14 + k] = mk(1, 0, 4, 4, 0, 0, 4, 0, 0, 1, 1);
        for (int k = 4; k < 8; k++) tbl[13 + k] = mk(0, 1, k, k, 0, 0, k, k == 7, 0, 1, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        tbl[22] = zero;

        rst = 1'b1;
        bus_if.trg = 1'b0; bus_if.abort = 1'b0; bus_if.stall = 1'b0; bus_if.mode = 1'b0;
        bus_if.row_last = '0; bus_if.col_last = '0;
        #1 rst = 1'b0;
        #1 chk_outs("reset", zero);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // abort beats trg in IDLE
        bus_if.trg = 1'b1; bus_if.abort = 1'b1;
        tick();
        bus_if.trg = 1'b0; bus_if.abort = 1'b0;
        check("abort_over_trg.state", 32'(bus_if.state), 0);
        check("abort_over_trg.busy",  32'(bus_if.busy),  0);

        start(0, 0, 31);
        run_table(0, 10);
        start(0, 0, 31);
        run_table(10, 13);

        // Two rows, two column blocks; trg held high mid-sweep must be ignored.
        start(0, 1, 63);
        bus_if.trg = 1'b1;
        for (int b = 0; b < 32; b++) begin
            int r;
            r = b % 16;
            chk_outs($sformatf("two_row_b%0d", b),
                     mk(0, 1, r, (b < 8) ? b : 8, b / 16, (r >= 8) ? 32 : 0, r % 8, r == 15, 0, 1, 1));
            if (b == 29) bus_if.trg = 1'b0;
            tick();
        end
        chk_outs("two_row_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2));
        tick();
        chk_outs("two_row_idle", zero);

        // Abort at beat 10.
        start(0, 1, 63);
        for (int b = 0; b < 10; b++) tick();
        check("abort_pre.coe_adr", 32'(bus_if.coe_adr), 10);
        check("abort_pre.col_cnt", 32'(bus_if.col_cnt), 32);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        chk_outs("abort_post", zero);
        tick();
        check("abort_nodone.done",  32'(bus_if.done),  0);
        check("abort_nodone.state", 32'(bus_if.state), 0);

        // Continuous sweeps; mode cleared inside the third sweep.
        start(1, 0, 31);
        for (int c = 0; c < 24; c++) begin
            check($sformatf("cont_c%0d.done", c),    32'(bus_if.done),    32'(c > 0 && c % 8 == 0));
            check($sformatf("cont_c%0d.busy", c),    32'(bus_if.busy),    1);
            check($sformatf("cont_c%0d.coe_adr", c), 32'(bus_if.coe_adr), c % 8);
            check($sformatf("cont_c%0d.state", c),   32'(bus_if.state),   1);
            if (c == 20) bus_if.mode = 1'b0;
            tick();
        end
        chk_outs("cont_last_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2));
        tick();
        chk_outs("cont_idle", zero);
        tick();
        check("cont_no_extra.done", 32'(bus_if.done), 0);

        // Asynchronous reset mid-run with trg held.
        start(0, 1, 63);
        bus_if.trg = 1'b1;
        for (int b = 0; b < 5; b++) tick();
        check("rst_pre.coe_adr", 32'(bus_if.coe_adr), 5);
        #1 rst = 1'b0;
        #1 chk_outs("rst_async", zero);
        tick();
        tick();
        check("rst_trg_ignored.state", 32'(bus_if.state), 0);
        check("rst_trg_ignored.busy",  32'(bus_if.busy),  0);
        bus_if.trg = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_outs($sformatf("post_rst_idle%0d", k), zero);
        end
        start(0, 0, 31);
        check("post_rst_start.state", 32'(bus_if.state),   1);
        check("post_rst_start.vld",   32'(bus_if.vld),     1);
        check("post_rst_start.coe",   32'(bus_if.coe_adr), 0);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
